// File: rtl/axis_frame_arbiter.sv
// Round-robin, frame-atomic AXI4-Stream arbiter with a single registered output stage.
// Optional source tagging on m_axis_tid is enabled by defining AXIS_FRAME_ARBITER_TAG_EN.
module axis_frame_arbiter #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int USER_WIDTH  = 1,
  parameter int ID_WIDTH    = 4,
  parameter int LAST_ENABLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index
);

  localparam int GI_W = $clog2(S_COUNT);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [GI_W-1:0]       ptr_q, ptr_d;
  logic [GI_W-1:0]       grant_index_q, grant_index_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

  logic [2*S_COUNT-1:0]  req_rot;
  logic [GI_W-1:0]       arb_idx;
  int                    arb_off;
  int                    arb_sel;

  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic [USER_WIDTH-1:0] sel_tuser;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic                  out_ready;
  logic                  beat_xfer;

  // Rotate requests so bit 0 is the source just after the pointer; lowest set bit wins.
  always_comb begin
    req_rot = {s_axis_tvalid, s_axis_tvalid} >> (int'(ptr_q) + 1);
    arb_off = 0;
    for (int k = S_COUNT - 1; k >= 0; k--) begin
      if (req_rot[k]) arb_off = k;
    end
    arb_sel = (int'(ptr_q) + 1 + arb_off) % S_COUNT;
    arb_idx = GI_W'(arb_sel);
  end

  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tuser  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index_q == GI_W'(i)) begin
        sel_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tuser  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
      end
    end
  end

  assign out_ready = m_axis_tready || !m_tvalid_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_index_d = grant_index_q;
    m_tvalid_d    = m_tvalid_q && !m_axis_tready;
    m_tdata_d     = m_tdata_q;
    m_tkeep_d     = m_tkeep_q;
    m_tlast_d     = m_tlast_q;
    m_tuser_d     = m_tuser_q;
    s_axis_tready = '0;
    beat_xfer     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          grant_index_d = arb_idx;
          ptr_d         = arb_idx;
          state_d       = ACTIVE;
        end
      end
      ACTIVE: begin
        s_axis_tready = S_COUNT'(out_ready) << grant_index_q;
        beat_xfer     = out_ready && sel_tvalid;
        if (beat_xfer) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = sel_tdata;
          m_tkeep_d  = sel_tkeep;
          m_tlast_d  = sel_tlast;
          m_tuser_d  = sel_tuser;
          if (sel_tlast || (LAST_ENABLE == 0)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= GI_W'(S_COUNT - 1);
      grant_index_q <= '0;
      m_tvalid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_index_q <= grant_index_d;
      m_tvalid_q    <= m_tvalid_d;
    end
  end

  // Output payload carries no reset; it is qualified by m_tvalid_q.
  always_ff @(posedge clk) begin
    m_tdata_q <= m_tdata_d;
    m_tkeep_q <= m_tkeep_d;
    m_tlast_q <= m_tlast_d;
    m_tuser_q <= m_tuser_d;
  end

`ifdef AXIS_FRAME_ARBITER_TAG_EN
  logic [ID_WIDTH-1:0] m_tid_q, m_tid_d;

  always_comb begin
    m_tid_d = m_tid_q;
    if (beat_xfer) m_tid_d = ID_WIDTH'(grant_index_q);
  end

  always_ff @(posedge clk) begin
    m_tid_q <= m_tid_d;
  end

  assign m_axis_tid = m_tid_q;
`else
  assign m_axis_tid = '0;
`endif

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign grant_valid   = (state_q == ACTIVE);
  assign grant_index   = grant_index_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: frame-atomic and beat-level (LAST_ENABLE=0) instances.
module tb_axis_frame_arbiter;

  logic        clk;
  logic        rst;

  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [7:0]  m_tdata;
  logic [0:0]  m_tkeep, m_tuser;
  logic        m_tvalid, m_tready, m_tlast;
  logic [3:0]  m_tid;
  logic        gv;
  logic [1:0]  gi;

  logic [31:0] b_tdata;
  logic [3:0]  b_tkeep, b_tvalid, b_tready, b_tlast, b_tuser;
  logic [7:0]  bm_tdata;
  logic [0:0]  bm_tkeep, bm_tuser;
  logic        bm_tvalid, bm_tready, bm_tlast;
  logic [3:0]  bm_tid;
  logic        b_gv;
  logic [1:0]  b_gi;

  int n_tests = 0;
  int n_fail  = 0;

  axis_frame_arbiter #(.S_COUNT(4), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1),
                       .ID_WIDTH(4), .LAST_ENABLE(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tuser(m_tuser), .grant_valid(gv), .grant_index(gi)
  );

  axis_frame_arbiter #(.S_COUNT(4), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1),
                       .ID_WIDTH(4), .LAST_ENABLE(0)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser),
    .m_axis_tdata(bm_tdata), .m_axis_tkeep(bm_tkeep), .m_axis_tvalid(bm_tvalid),
    .m_axis_tready(bm_tready), .m_axis_tlast(bm_tlast), .m_axis_tid(bm_tid),
    .m_axis_tuser(bm_tuser), .grant_valid(b_gv), .grant_index(b_gi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [7:0] d, input logic l);
    s_tvalid[i]      = v;
    s_tdata[i*8 +: 8] = d;
    s_tlast[i]       = l;
  endtask

  function automatic logic [3:0] exp_tid(input int s);
`ifdef AXIS_FRAME_ARBITER_TAG_EN
    return 4'(s);
`else
    return 4'd0;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tkeep = '1; s_tvalid = '0; s_tlast = '0; s_tuser = 4'b1010;
    m_tready = 1'b1;
    b_tdata = '0; b_tkeep = '1; b_tvalid = '0; b_tlast = '0; b_tuser = '0;
    bm_tready = 1'b1;
    repeat (3) tick();
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_gv", gv, 0);
    chk("rst_gi", gi, 0);
    rst = 1'b0;
    tick();

    // Test 1: three-beat frame from source 0
    set_src(0, 1, 8'h11, 0);
    tick();
    chk("t1_gv", gv, 1);
    chk("t1_gi", gi, 0);
    chk("t1_tready", s_tready, 4'b0001);
    chk("t1_mvalid_pre", m_tvalid, 0);
    tick();
    chk("t1_d0", m_tdata, 8'h11);
    chk("t1_v0", m_tvalid, 1);
    chk("t1_l0", m_tlast, 0);
    chk("t1_tid", m_tid, exp_tid(0));
    chk("t1_user", m_tuser, 0);
    chk("t1_keep", m_tkeep, 1);
    set_src(0, 1, 8'h22, 0);
    tick();
    chk("t1_d1", m_tdata, 8'h22);
    chk("t1_v1", m_tvalid, 1);
    set_src(0, 1, 8'h33, 1);
    tick();
    chk("t1_d2", m_tdata, 8'h33);
    chk("t1_l2", m_tlast, 1);
    chk("t1_gv_end", gv, 0);
    chk("t1_gi_hold", gi, 0);
    chk("t1_tready_idle", s_tready, 0);
    set_src(0, 0, 8'h00, 0);
    tick();
    chk("t1_drain", m_tvalid, 0);

    // Test 2: all sources request one-beat frames after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_src(i, 1, 8'hA0 + 8'(i), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_bubble", m_tvalid, 0);
      chk("t2_gi", gi, 32'(k % 4));
      chk("t2_gv", gv, 1);
      tick();
      chk("t2_valid", m_tvalid, 1);
      chk("t2_data", m_tdata, 32'(8'hA0 + 8'(k % 4)));
      chk("t2_tid", m_tid, exp_tid(k % 4));
      chk("t2_gv_end", gv, 0);
    end
    s_tvalid = '0;
    tick();
    chk("t2_drain", m_tvalid, 0);

    // Test 3: output backpressure mid-frame on source 2
    set_src(2, 1, 8'h51, 0);
    tick();
    chk("t3_gi", gi, 2);
    tick();
    chk("t3_d0", m_tdata, 8'h51);
    set_src(2, 1, 8'h52, 0);
    set_src(1, 1, 8'h61, 1);
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_data", m_tdata, 8'h51);
      chk("t3_hold_valid", m_tvalid, 1);
      chk("t3_hold_tready", s_tready, 0);
      chk("t3_hold_gi", gi, 2);
    end
    m_tready = 1'b1;
    tick();
    chk("t3_d1", m_tdata, 8'h52);
    chk("t3_v1", m_tvalid, 1);
    set_src(2, 1, 8'h53, 1);
    tick();
    chk("t3_d2", m_tdata, 8'h53);
    chk("t3_l2", m_tlast, 1);
    chk("t3_gv_end", gv, 0);
    set_src(2, 0, 8'h00, 0);
    tick();
    chk("t3_gi_next", gi, 1);
    chk("t3_gv_next", gv, 1);
    chk("t3_bubble", m_tvalid, 0);
    tick();
    chk("t3_src1_data", m_tdata, 8'h61);
    chk("t3_src1_tid", m_tid, exp_tid(1));
    set_src(1, 0, 8'h00, 0);
    tick();
    chk("t3_drain", m_tvalid, 0);

    // Test 4: granted source 1 stalls while source 3 waits
    set_src(1, 1, 8'h71, 0);
    tick();
    chk("t4_gi", gi, 1);
    tick();
    chk("t4_d0", m_tdata, 8'h71);
    set_src(1, 0, 8'h00, 0);
    set_src(3, 1, 8'h91, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stall_valid", m_tvalid, 0);
      chk("t4_stall_gi", gi, 1);
      chk("t4_stall_gv", gv, 1);
      chk("t4_stall_tready", s_tready, 4'b0010);
    end
    set_src(1, 1, 8'h72, 1);
    tick();
    chk("t4_d1", m_tdata, 8'h72);
    chk("t4_v1", m_tvalid, 1);
    chk("t4_user", m_tuser, 1);
    chk("t4_gv_end", gv, 0);
    set_src(1, 0, 8'h00, 0);
    tick();
    chk("t4_gi3", gi, 3);
    tick();
    chk("t4_src3_data", m_tdata, 8'h91);
    chk("t4_src3_tid", m_tid, exp_tid(3));
    set_src(3, 0, 8'h00, 0);
    tick();

    // Test 5: reset during beat 2 of a source 0 frame
    set_src(0, 1, 8'hC1, 0);
    tick();
    chk("t5_gi", gi, 0);
    tick();
    chk("t5_d0", m_tdata, 8'hC1);
    set_src(0, 1, 8'hC2, 0);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", m_tvalid, 0);
    chk("t5_rst_gv", gv, 0);
    chk("t5_rst_tready", s_tready, 0);
    chk("t5_rst_gi", gi, 0);
    rst = 1'b0;
    set_src(0, 1, 8'hC3, 0);
    set_src(3, 1, 8'hD1, 1);
    tick();
    chk("t5_regrant", gi, 0);
    chk("t5_regrant_gv", gv, 1);
    tick();
    chk("t5_d2", m_tdata, 8'hC3);
    set_src(0, 1, 8'hC4, 1);
    tick();
    chk("t5_d3", m_tdata, 8'hC4);
    set_src(0, 0, 8'h00, 0);
    tick();
    chk("t5_gi3", gi, 3);
    tick();
    chk("t5_src3_data", m_tdata, 8'hD1);
    set_src(3, 0, 8'h00, 0);
    tick();

    // Test 6: beat-level round robin when LAST_ENABLE=0
    b_tdata[7:0]  = 8'hE0;
    b_tdata[15:8] = 8'hE1;
    b_tvalid      = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_gi", b_gi, 32'(k % 2));
      chk("t6_gv", b_gv, 1);
      chk("t6_bubble", bm_tvalid, 0);
      tick();
      chk("t6_valid", bm_tvalid, 1);
      chk("t6_data", bm_tdata, 32'(8'hE0 + 8'(k % 2)));
      chk("t6_gv_end", b_gv, 0);
    end
    b_tvalid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Round-robin, frame-atomic arbiter that shares one AXI4-Stream sink (normally the input of a shared FIFO instance) between S_COUNT source streams.
- Grants one source at a time and holds the grant until that source's tlast beat is accepted.
- Drives a single registered output stage.
- Reports the current grant for debug and accounting.

Parameters:
- S_COUNT, 4: number of source ports; range 2..16.
- DATA_WIDTH, 8: tdata width per port.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width per port.
- USER_WIDTH, 1: tuser width per port.
- ID_WIDTH, 4: m_axis_tid width; must be >= $clog2(S_COUNT).
- LAST_ENABLE, 1: 1 = hold grant until tlast; 0 = every beat is treated as a frame (beat-level round-robin).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed source data; port i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed tkeep
- s_axis_tvalid  in  S_COUNT  per-source valid
- s_axis_tready  out  S_COUNT  per-source ready
- s_axis_tlast  in  S_COUNT  per-source last
- s_axis_tuser  in  S_COUNT*USER_WIDTH  packed tuser
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output keep
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- m_axis_tid  out  ID_WIDTH  source tag (see Optional Feature)
- m_axis_tuser  out  USER_WIDTH  output user
- grant_valid  out  1  arbiter is in ACTIVE state
- grant_index  out  $clog2(S_COUNT)  currently or last granted source

Behaviour:
- Reset values:
  - m_axis_tvalid=0, s_axis_tready=0, grant_valid=0, grant_index=0.
  - Round-robin pointer = S_COUNT-1, so source 0 has highest priority after reset.
  - Output data registers are don't-care.
- State machine, two states: IDLE and ACTIVE.
- IDLE:
  - If any s_axis_tvalid bit is set, select the first asserted source searching upward from (pointer+1) mod S_COUNT, with wrap-around.
  - Register it into grant_index, set grant_valid=1, set pointer=selected, and move to ACTIVE.
  - If no tvalid is set, stay in IDLE.
  - All s_axis_tready are 0 in IDLE.
- ACTIVE:
  - s_axis_tready[grant_index] = (m_axis_tready || !m_axis_tvalid); all other tready bits are 0.
  - A beat transfers when that tready and the granted tvalid are both high.
  - On transfer, the beat's data, keep, last and user are registered into the output stage and m_axis_tvalid is set to 1.
  - If the output stage is accepted and no new beat arrives, m_axis_tvalid is cleared to 0.
  - A beat with tlast=1 (or any beat when LAST_ENABLE=0) ends the grant: next state IDLE, grant_valid=0, grant_index holds its value.
- Latency:
  - Source tvalid rising in an IDLE cycle at edge N → grant at edge N+1 → first beat on m_axis at edge N+2.
  - One-cycle arbitration bubble between consecutive frames.
  - Sustained throughput within a frame is 1 beat/cycle while m_axis_tready=1.
- Backpressure:
  - With m_axis_tready=0 and m_axis_tvalid=1, the output registers hold stable and s_axis_tready is 0.
  - Grant is never revoked mid-frame, even if the granted source drops tvalid; the arbiter waits in ACTIVE.
- Requests from non-granted sources during ACTIVE are ignored until IDLE; no starvation under round-robin.
- Simultaneous requests in IDLE: the lowest index at or after pointer+1 wins, e.g. pointer=1 with tvalid=4'b1011 selects 3.
- Reset mid-frame:
  - Returns to IDLE and drops the output beat (m_axis_tvalid=0); the partial frame is not completed.
  - The source-side frame remainder is the upstream's responsibility.
- grant_index width: when S_COUNT is a power of two, it wraps naturally; otherwise the pointer increment is modulo S_COUNT.

Optional Feature:
- Macro AXIS_FRAME_ARBITER_TAG_EN.
- Defined: m_axis_tid = grant_index zero-extended to ID_WIDTH, registered with each beat.
- Undefined: m_axis_tid is constant 0, and grant_index / grant_valid remain as status outputs only.

Test Plan:
1. Reset, then source 0 sends a 3-beat frame (tdata 0x11,0x22,0x33; last on 0x33) with m_axis_tready=1 → first beat at edge 2 after tvalid, beats on 3 consecutive cycles, grant_valid drops after 0x33 accepted, tid=0 when TAG_EN.
2. All 4 sources assert valid with 1-beat frames after reset → output order 0,1,2,3,0, each separated by one idle cycle, tid matches source.
3. Source 2 mid-frame holds m_axis_tready=0 for 5 cycles → m_axis_tdata stable, s_axis_tready=0 throughout, no beat lost or duplicated; source 1 valid meanwhile is not granted until source 2's tlast.
4. Granted source 1 deasserts tvalid for 3 cycles mid-frame while source 3 is valid → grant stays on 1, m_axis_tvalid goes 0 after the last accepted beat, and resumes with source 1 data.
5. Assert rst during beat 2 of a 4-beat frame → next cycle m_axis_tvalid=0, grant_valid=0, all tready=0; a new request from source 3 is then granted before source 0's leftovers only if pointer rules say so (pointer reset=3 ⇒ source 0 first if both valid).
6. LAST_ENABLE=0, sources 0 and 1 continuously valid → output alternates 0,1,0,1 one beat per grant.
